psram_cmd_scheduler: RTL and testbench
======================================

PSRAM_CMD_SCHEDULER -- requirements
Module: psram_cmd_scheduler

Interface
REQ-001 SHALL have parameter TCMD_CLKS, default 38, giving the minimum memory_clk cycles between successive cmd_en rising edges.
REQ-002 SHALL have parameter BEATS, default 8, giving the number of 64-bit beats per burst.
REQ-003 SHALL have port memory_clk, input, 1 bit: the clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port init_calib, input, 1 bit: PSRAM calibration done; no command is issued while low.
REQ-006 SHALL have ports wr_req_valid (input, 1), wr_req_ready (output, 1) and wr_req_addr (input, 21): write-burst request handshake.
REQ-007 SHALL have ports wr_beat_valid (input, 1), wr_beat_ready (output, 1), wr_beat_data (input, 64) and wr_beat_mask (input, 8): write beat stream; mask bit 1 = byte not written.
REQ-008 SHALL have ports rd_req_valid (input, 1), rd_req_ready (output, 1) and rd_req_addr (input, 21): read-burst request handshake.
REQ-009 SHALL have ports cmd_en (output, 1), cmd (output, 1, 1 = write), addr (output, 21), wr_data (output, 64) and data_mask (output, 8): PSRAM command bus.
REQ-010 SHALL have port busy, output, 1 bit: high from command issue until the Tcmd window expires.

Function
REQ-011 Write beats SHALL be accepted on wr_beat_valid&&wr_beat_ready into a BEATS-deep, 72-bit staging buffer; wr_beat_ready SHALL be low while the buffer holds BEATS beats.
REQ-012 A write request SHALL be eligible only when the buffer holds BEATS beats and wr_req_valid is high; a read request only when rd_req_valid is high.
REQ-013 The FSM SHALL have states IDLE, WR_ISSUE, RD_ISSUE and GAP; it SHALL leave IDLE only when init_calib is high.
REQ-014 IDLE SHALL go to WR_ISSUE or RD_ISSUE on an eligible request; when both are eligible, the grant SHALL alternate, with read first after reset.
REQ-015 The request ready (wr_req_ready or rd_req_ready) SHALL pulse for exactly the one cycle of leaving IDLE, and addr/cmd SHALL be latched in that cycle.
REQ-016 cmd_en SHALL be high for exactly 2 memory_clk cycles, starting the cycle after the grant.
REQ-017 In WR_ISSUE, beat k (k = 0..BEATS-1) SHALL be driven on wr_data/data_mask for memory_clk cycles 2k and 2k+1 counted from the cmd_en rising edge; the beat SHALL be popped from the buffer after cycle 2k+1.
REQ-018 RD_ISSUE SHALL last 2 cycles; wr_data SHALL be 0 and data_mask SHALL be 8'hFF outside WR_ISSUE.
REQ-019 A Tcmd counter SHALL start at 1 on the cmd_en rising edge; GAP SHALL return to IDLE when the counter equals TCMD_CLKS, so the next cmd_en rise is at least TCMD_CLKS+1 cycles after the previous one.
REQ-020 addr SHALL stay stable from the cmd_en rise until the end of GAP.
REQ-021 Beats SHALL continue to be accepted during GAP/RD_ISSUE while buffer space exists; a simultaneous push and pop SHALL keep the count unchanged.
REQ-022 If init_calib falls while not IDLE, the current burst SHALL complete; no new grant SHALL occur.

Reset
REQ-023 On rst_n low: FSM SHALL go to IDLE, buffer SHALL be emptied, counters zeroed, grant pointer set to read, and busy SHALL be 0.
REQ-024 On rst_n low, outputs SHALL be cmd_en=0, cmd=0, addr=0, wr_data=0, data_mask=8'hFF, all ready outputs=0, except wr_beat_ready=1 once out of reset.
REQ-025 Reset mid-burst SHALL abandon the burst immediately, with no further cmd_en.

Structure
REQ-026 A shared package psram_pkg SHALL hold TCMD_CLKS, BEATS, the address width 21, and the FSM state enumeration.
REQ-027 The staging buffer SHALL be a sub-module psram_wr_beat_fifo (BEATS x 72, count output, synchronous push/pop).

Verification
REQ-028 The bench SHALL hold init_calib=0 and present requests -> no cmd_en; after init_calib=1, the first cmd_en comes within 3 cycles.
REQ-029 The bench SHALL send 8 beats with data 0x0..07 and a write request to addr 0x00010 -> cmd_en for 2 cycles, cmd=1, and wr_data steps 0..7 every 2 cycles.
REQ-030 The bench SHALL present write and read requests both valid continuously -> order R,W,R,W, with cmd_en rises spaced exactly 39 cycles apart.
REQ-031 The bench SHALL push a 9th beat while the buffer is full -> wr_beat_ready=0 and no data loss; a beat with mask 8'h0F is forwarded unchanged.
REQ-032 The bench SHALL assert rst_n low at cycle 5 of WR_ISSUE -> cmd_en=0 and data_mask=FF immediately, and the buffer count reads 0 after release.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared constants and FSM state encoding for the PSRAM command scheduler.
package psram_pkg;
  localparam int TCMD_CLKS = 38;
  localparam int BEATS     = 8;
  localparam int ADDR_W    = 21;
  localparam int DATA_W    = 64;
  localparam int MASK_W    = 8;
  localparam int BEAT_W    = DATA_W + MASK_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_ISSUE = 2'd1,
    RD_ISSUE = 2'd2,
    GAP      = 2'd3
  } state_e;
endpackage

// File: rtl/psram_cmd_scheduler_if.sv
// Request, write-beat and PSRAM command bus between a client (master) and the scheduler (slave).
interface psram_cmd_scheduler_if;
  import psram_pkg::*;

  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic              wr_beat_valid;
  logic              wr_beat_ready;
  logic [DATA_W-1:0] wr_beat_data;
  logic [MASK_W-1:0] wr_beat_mask;
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              cmd_en;
  logic              cmd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [MASK_W-1:0] data_mask;

  modport master (
    output wr_req_valid, wr_req_addr, wr_beat_valid, wr_beat_data, wr_beat_mask,
           rd_req_valid, rd_req_addr,
    input  wr_req_ready, wr_beat_ready, rd_req_ready,
           cmd_en, cmd, addr, wr_data, data_mask
  );

  modport slave (
    input  wr_req_valid, wr_req_addr, wr_beat_valid, wr_beat_data, wr_beat_mask,
           rd_req_valid, rd_req_addr,
    output wr_req_ready, wr_beat_ready, rd_req_ready,
           cmd_en, cmd, addr, wr_data, data_mask
  );
endinterface

// File: rtl/psram_wr_beat_fifo.sv
// Write-beat staging FIFO: BEATS entries of {mask, data}, head exposed without a pop.
module psram_wr_beat_fifo #(
  parameter int BEATS = 8,
  parameter int WIDTH = 72
) (
  input  logic                       memory_clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           push_data_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(BEATS+1)-1:0] count_o
);
  localparam int PW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NW = $clog2(BEATS + 1);

  logic [WIDTH-1:0] mem_q [BEATS];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != NW'(BEATS));
  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge memory_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= (wr_ptr_q == PW'(BEATS - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= (rd_ptr_q == PW'(BEATS - 1)) ? '0 : rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + NW'(1);
        2'b01:   count_q <= count_q - NW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge memory_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/psram_cmd_scheduler.sv
// PSRAM command scheduler: stages write beats, arbitrates read/write bursts, spaces cmd_en by Tcmd.
//   state    | meaning
//   IDLE     | waiting for calibration and an eligible request
//   WR_ISSUE | cmd_en pulse, then BEATS staged beats at two cycles each
//   RD_ISSUE | two-cycle read command
//   GAP      | holding off until the Tcmd window expires
module psram_cmd_scheduler #(
  parameter int TCMD_CLKS = psram_pkg::TCMD_CLKS,
  parameter int BEATS     = psram_pkg::BEATS
) (
  input  logic                 memory_clk,
  input  logic                 rst_n,
  input  logic                 init_calib,
  output logic                 busy,
  psram_cmd_scheduler_if.slave sched_if
);
  import psram_pkg::*;

  localparam int CW = $clog2(TCMD_CLKS + 1);
  localparam int NW = $clog2(BEATS + 1);

  state_e            state_q;
  logic [CW-1:0]     tcmd_q;
  logic              prefer_rd_q, busy_q, cmd_en_q, cmd_q, out_of_rst_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NW-1:0]     fifo_count;
  logic [BEAT_W-1:0] fifo_head;
  logic              fifo_full, push, pop;
  logic              wr_elig, rd_elig, can_grant, grant_wr, grant_rd;

  assign fifo_full = (fifo_count == NW'(BEATS));
  assign push      = sched_if.wr_beat_valid && sched_if.wr_beat_ready;
  // tcmd_q counts from 1 on the cmd_en rise, so an even value marks the second cycle of a beat.
  assign pop       = (state_q == WR_ISSUE) && !tcmd_q[0];

  assign wr_elig   = fifo_full && sched_if.wr_req_valid;
  assign rd_elig   = sched_if.rd_req_valid;
  assign can_grant = (state_q == IDLE) && init_calib;
  assign grant_rd  = can_grant && rd_elig && (!wr_elig || prefer_rd_q);
  assign grant_wr  = can_grant && wr_elig && (!rd_elig || !prefer_rd_q);

  assign sched_if.wr_req_ready  = grant_wr;
  assign sched_if.rd_req_ready  = grant_rd;
  assign sched_if.wr_beat_ready = out_of_rst_q && !fifo_full;
  assign sched_if.cmd_en        = cmd_en_q;
  assign sched_if.cmd           = cmd_q;
  assign sched_if.addr          = addr_q;
  assign sched_if.wr_data       = (state_q == WR_ISSUE) ? fifo_head[DATA_W-1:0] : '0;
  assign sched_if.data_mask     = (state_q == WR_ISSUE) ? fifo_head[BEAT_W-1:DATA_W] : '1;
  assign busy                   = busy_q;

  psram_wr_beat_fifo #(
    .BEATS (BEATS),
    .WIDTH (BEAT_W)
  ) u_fifo (
    .memory_clk  (memory_clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i ({sched_if.wr_beat_mask, sched_if.wr_beat_data}),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  always_ff @(posedge memory_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tcmd_q       <= '0;
      prefer_rd_q  <= 1'b1;
      busy_q       <= 1'b0;
      cmd_en_q     <= 1'b0;
      cmd_q        <= 1'b0;
      addr_q       <= '0;
      out_of_rst_q <= 1'b0;
    end else begin
      out_of_rst_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (grant_rd || grant_wr) begin
            state_q     <= grant_wr ? WR_ISSUE : RD_ISSUE;
            prefer_rd_q <= grant_wr;
            cmd_q       <= grant_wr;
            addr_q      <= grant_wr ? sched_if.wr_req_addr : sched_if.rd_req_addr;
            cmd_en_q    <= 1'b1;
            busy_q      <= 1'b1;
            tcmd_q      <= CW'(1);
          end
        end
        WR_ISSUE: begin
          tcmd_q <= tcmd_q + CW'(1);
          if (tcmd_q == CW'(2)) cmd_en_q <= 1'b0;
          if (tcmd_q == CW'(2 * BEATS)) state_q <= GAP;
        end
        RD_ISSUE: begin
          tcmd_q <= tcmd_q + CW'(1);
          if (tcmd_q == CW'(2)) begin
            cmd_en_q <= 1'b0;
            state_q  <= GAP;
          end
        end
        GAP: begin
          if (tcmd_q == CW'(TCMD_CLKS)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            tcmd_q  <= '0;
          end else begin
            tcmd_q <= tcmd_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psram_cmd_scheduler.sv
// Directed bench for psram_cmd_scheduler with hand-computed expectations.
module tb_psram_cmd_scheduler;
  localparam int TCMD  = 38;
  localparam int BEATS = 8;

  logic memory_clk = 1'b0;
  logic rst_n      = 1'b0;
  logic init_calib = 1'b0;
  logic busy;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   rise_cyc[$];
  logic rise_cmd[$];
  logic cmd_en_prev = 1'b0;

  psram_cmd_scheduler_if bus ();

  psram_cmd_scheduler #(
    .TCMD_CLKS (TCMD),
    .BEATS     (BEATS)
  ) dut (
    .memory_clk (memory_clk),
    .rst_n      (rst_n),
    .init_calib (init_calib),
    .busy       (busy),
    .sched_if   (bus)
  );

  always #5 memory_clk = ~memory_clk;
  always @(posedge memory_clk) cyc++;

  always @(negedge memory_clk) begin
    if (bus.cmd_en && !cmd_en_prev) begin
      rise_cyc.push_back(cyc);
      rise_cmd.push_back(bus.cmd);
    end
    cmd_en_prev = bus.cmd_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge memory_clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check_eq("wait_idle", busy, 1'b0);
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [7:0] m);
    int n = 0;
    bus.wr_beat_valid = 1'b1;
    bus.wr_beat_data  = d;
    bus.wr_beat_mask  = m;
    #1;
    while (!bus.wr_beat_ready && n < 100) begin
      tick();
      n++;
    end
    check_eq("push_ready", bus.wr_beat_ready, 1'b1);
    tick();
    bus.wr_beat_valid = 1'b0;
  endtask

  task automatic fill_until_full();
    int n = 0;
    bus.wr_beat_valid = 1'b1;
    #1;
    while (bus.wr_beat_ready && n < 20) begin
      tick();
      n++;
    end
    bus.wr_beat_valid = 1'b0;
  endtask

  initial begin
    int   n;
    logic acc;
    bus.wr_req_valid  = 1'b0;
    bus.wr_req_addr   = '0;
    bus.wr_beat_valid = 1'b0;
    bus.wr_beat_data  = '0;
    bus.wr_beat_mask  = '0;
    bus.rd_req_valid  = 1'b0;
    bus.rd_req_addr   = '0;

    // Reset values
    #2;
    check_eq("rst_cmd_en", bus.cmd_en, 1'b0);
    check_eq("rst_cmd", bus.cmd, 1'b0);
    check_eq("rst_addr", bus.addr, 21'h0);
    check_eq("rst_wr_data", bus.wr_data, 64'h0);
    check_eq("rst_data_mask", bus.data_mask, 8'hFF);
    check_eq("rst_wr_req_ready", bus.wr_req_ready, 1'b0);
    check_eq("rst_rd_req_ready", bus.rd_req_ready, 1'b0);
    check_eq("rst_wr_beat_ready", bus.wr_beat_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("beat_ready_after_rst", bus.wr_beat_ready, 1'b1);

    // No command without calibration; first command soon after it
    bus.rd_req_addr  = 21'h1ABCD;
    bus.rd_req_valid = 1'b1;
    bus.wr_req_valid = 1'b1;
    rise_cyc.delete();
    rise_cmd.delete();
    for (int i = 0; i < 20; i++) tick();
    check_eq("nocal_rises", rise_cyc.size(), 0);
    check_eq("nocal_rd_ready", bus.rd_req_ready, 1'b0);
    init_calib = 1'b1;
    #1;
    check_eq("cal_rd_ready", bus.rd_req_ready, 1'b1);
    n = 0;
    while (!bus.cmd_en && n < 3) begin
      tick();
      n++;
    end
    bus.rd_req_valid = 1'b0;
    bus.wr_req_valid = 1'b0;
    check_eq("cal_first_cmd_en", bus.cmd_en, 1'b1);
    check_eq("rd_cmd", bus.cmd, 1'b0);
    check_eq("rd_addr", bus.addr, 21'h1ABCD);
    check_eq("rd_busy", busy, 1'b1);
    check_eq("rd_ready_pulse", bus.rd_req_ready, 1'b0);
    check_eq("rd_data_mask", bus.data_mask, 8'hFF);
    tick();
    check_eq("rd_cmd_en_2nd", bus.cmd_en, 1'b1);
    tick();
    check_eq("rd_cmd_en_off", bus.cmd_en, 1'b0);
    check_eq("rd_gap_addr", bus.addr, 21'h1ABCD);
    wait_idle();

    // Write burst of 8 beats, beat 3 carries mask 0F, plus a 9th beat held while full
    for (int k = 0; k < BEATS; k++) push_beat(64'(k), (k == 3) ? 8'h0F : 8'h00);
    bus.wr_beat_valid = 1'b1;
    bus.wr_beat_data  = 64'h99;
    bus.wr_beat_mask  = 8'hAA;
    #1;
    check_eq("full_beat_ready", bus.wr_beat_ready, 1'b0);
    bus.wr_req_addr  = 21'h00010;
    bus.wr_req_valid = 1'b1;
    #1;
    check_eq("wr_req_ready", bus.wr_req_ready, 1'b1);
    tick();
    bus.wr_req_valid = 1'b0;
    check_eq("wr_ready_pulse", bus.wr_req_ready, 1'b0);
    check_eq("wr_cmd", bus.cmd, 1'b1);
    check_eq("wr_addr", bus.addr, 21'h00010);
    check_eq("wr_busy", busy, 1'b1);
    for (int i = 0; i < 2 * BEATS; i++) begin
      check_eq("wr_data", bus.wr_data, 64'(i / 2));
      check_eq("wr_mask", bus.data_mask, (i / 2 == 3) ? 8'h0F : 8'h00);
      check_eq("wr_cmd_en", bus.cmd_en, (i < 2) ? 1'b1 : 1'b0);
      acc = bus.wr_beat_valid && bus.wr_beat_ready;
      tick();
      if (acc) bus.wr_beat_valid = 1'b0;
    end
    check_eq("gap_wr_data", bus.wr_data, 64'h0);
    check_eq("gap_data_mask", bus.data_mask, 8'hFF);
    check_eq("gap_addr", bus.addr, 21'h00010);
    check_eq("gap_busy", busy, 1'b1);
    check_eq("gap_count", dut.u_fifo.count_o, 4'd1);
    wait_idle();

    // Held 9th beat leads the next burst unchanged
    for (int k = 0; k < BEATS - 1; k++) push_beat(64'h100 + 64'(k), 8'h00);
    bus.wr_req_addr  = 21'h00020;
    bus.wr_req_valid = 1'b1;
    tick();
    bus.wr_req_valid = 1'b0;
    check_eq("b9_data", bus.wr_data, 64'h99);
    check_eq("b9_mask", bus.data_mask, 8'hAA);
    check_eq("b9_addr", bus.addr, 21'h00020);
    tick();
    tick();
    check_eq("b10_data", bus.wr_data, 64'h100);
    check_eq("b10_mask", bus.data_mask, 8'h00);
    wait_idle();

    // Both requests held: alternate R,W,R,W spaced by Tcmd+1
    bus.wr_beat_data  = 64'h5A;
    bus.wr_beat_mask  = 8'h00;
    bus.wr_beat_valid = 1'b1;
    bus.rd_req_addr   = 21'h00300;
    bus.wr_req_addr   = 21'h00400;
    bus.rd_req_valid  = 1'b1;
    bus.wr_req_valid  = 1'b1;
    rise_cyc.delete();
    rise_cmd.delete();
    n = 0;
    while (rise_cyc.size() < 4 && n < 400) begin
      tick();
      n++;
    end
    bus.rd_req_valid  = 1'b0;
    bus.wr_req_valid  = 1'b0;
    bus.wr_beat_valid = 1'b0;
    check_eq("alt_n_rises", rise_cyc.size(), 4);
    for (int i = 0; i < rise_cyc.size() && i < 4; i++) begin
      check_eq("alt_order", rise_cmd[i], (i % 2 == 1) ? 1'b1 : 1'b0);
      if (i > 0) check_eq("alt_spacing", rise_cyc[i] - rise_cyc[i-1], TCMD + 1);
    end
    wait_idle();

    // Reset in the middle of a write burst
    fill_until_full();
    check_eq("pre_rst_count", dut.u_fifo.count_o, 4'd8);
    bus.wr_req_addr  = 21'h0001F;
    bus.wr_req_valid = 1'b1;
    tick();
    bus.wr_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("pre_rst_mask", bus.data_mask, 8'h00);
    check_eq("pre_rst_busy", busy, 1'b1);
    rise_cyc.delete();
    rise_cmd.delete();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_cmd_en", bus.cmd_en, 1'b0);
    check_eq("mid_rst_mask", bus.data_mask, 8'hFF);
    check_eq("mid_rst_data", bus.wr_data, 64'h0);
    check_eq("mid_rst_addr", bus.addr, 21'h0);
    check_eq("mid_rst_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("post_rst_count", dut.u_fifo.count_o, 4'd0);
    check_eq("post_rst_beat_ready", bus.wr_beat_ready, 1'b1);
    bus.wr_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.wr_req_valid = 1'b0;
    check_eq("post_rst_rises", rise_cyc.size(), 0);

    // Calibration lost mid-burst: burst completes, no new grant
    bus.rd_req_addr  = 21'h00002;
    bus.rd_req_valid = 1'b1;
    tick();
    check_eq("cl_cmd_en_1", bus.cmd_en, 1'b1);
    init_calib = 1'b0;
    tick();
    check_eq("cl_cmd_en_2", bus.cmd_en, 1'b1);
    tick();
    check_eq("cl_cmd_en_off", bus.cmd_en, 1'b0);
    wait_idle();
    rise_cyc.delete();
    rise_cmd.delete();
    for (int i = 0; i < 20; i++) tick();
    check_eq("cl_no_grant", rise_cyc.size(), 0);
    check_eq("cl_rd_ready", bus.rd_req_ready, 1'b0);
    init_calib = 1'b1;
    #1;
    check_eq("cl_rd_ready_back", bus.rd_req_ready, 1'b1);
    tick();
    bus.rd_req_valid = 1'b0;
    check_eq("cl_cmd_en_back", bus.cmd_en, 1'b1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
